// File: rtl/pipe_addsub.sv
// pipe_addsub: STAGES-deep pipelined signed adder/subtractor; stage k adds slice k of WIDTH/STAGES bits.
// Define PIPE_ADDSUB_CC_EN to build the carry/overflow/zero/sign flag logic; otherwise the flags are tied to 0.
module pipe_addsub #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             sign
);
    localparam int SW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    logic advance;

    // Stage registers; the last stage's sum register is the result output.
    logic             vld_q [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic [WIDTH-1:0] a_q   [LAST];
    logic [WIDTH-1:0] b_q   [LAST];
    logic             c_q   [LAST];

    // Per-stage combinational inputs and the slice each stage produces.
    logic [WIDTH-1:0] a_in      [STAGES];
    logic [WIDTH-1:0] b_in      [STAGES];
    logic [WIDTH-1:0] s_in      [STAGES];
    logic             c_in      [STAGES];
    logic [SW:0]      slice_sum [STAGES];
    logic [WIDTH-1:0] s_nxt     [STAGES];

    assign advance   = !(out_valid && !out_ready);
    assign in_ready  = advance;
    assign out_valid = vld_q[LAST];
    assign result    = s_q[LAST];

    always_comb begin
        // Subtraction is A + ~B + 1: op both inverts B and becomes the slice-0 carry-in.
        a_in[0] = a;
        b_in[0] = op ? ~b : b;
        s_in[0] = '0;
        c_in[0] = op;
        for (int k = 1; k < STAGES; k++) begin
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            s_in[k] = s_q[k-1];
            c_in[k] = c_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            slice_sum[k] = {1'b0, a_in[k][k*SW +: SW]} + {1'b0, b_in[k][k*SW +: SW]}
                         + {{SW{1'b0}}, c_in[k]};
            s_nxt[k] = s_in[k];
            s_nxt[k][k*SW +: SW] = slice_sum[k][SW-1:0];
        end
    end

    // NOTE: only valid bits and the visible result are reset; intermediate datapath registers
    // are qualified by their valid bit, so resetting them would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= 1'b0;
            end
            s_q[LAST] <= '0;
        end else if (advance) begin
            vld_q[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                vld_q[k] <= vld_q[k-1];
            end
            for (int k = 0; k < STAGES; k++) begin
                s_q[k] <= s_nxt[k];
            end
            for (int k = 0; k < LAST; k++) begin
                a_q[k] <= a_in[k];
                b_q[k] <= b_in[k];
                c_q[k] <= slice_sum[k][SW];
            end
        end
    end

`ifdef PIPE_ADDSUB_CC_EN
    // Carry into the MSB recovered from the MSB sum bit: sum = a ^ b ^ cin.
    logic msb_cin;
    assign msb_cin = a_in[LAST][WIDTH-1] ^ b_in[LAST][WIDTH-1] ^ s_nxt[LAST][WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            sign     <= 1'b0;
        end else if (advance) begin
            carry    <= slice_sum[LAST][SW];
            overflow <= msb_cin ^ slice_sum[LAST][SW];
            zero     <= (s_nxt[LAST] == '0);
            sign     <= s_nxt[LAST][WIDTH-1];
        end
    end
`else
    assign carry    = 1'b0;
    assign overflow = 1'b0;
    assign zero     = 1'b0;
    assign sign     = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_addsub.sv
// tb_pipe_addsub: directed vector table, stall/reset sequences and randomized traffic
// checked against an arithmetic reference model and an in-order expectation queue.
module tb_pipe_addsub;
    localparam int WIDTH  = 64;
    localparam int STAGES = 4;

`ifdef PIPE_ADDSUB_CC_EN
    localparam bit CC_ON = 1'b1;
`else
    localparam bit CC_ON = 1'b0;
`endif

    typedef logic [WIDTH-1:0] word_t;
    // flags packed as {carry, overflow, zero, sign}
    typedef struct {
        word_t      result;
        logic [3:0] flags;
    } res_t;
    typedef struct {
        logic       op;
        word_t      a;
        word_t      b;
        word_t      exp_result;
        logic [3:0] exp_flags;
    } vec_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  in_valid = 1'b0;
    logic  in_ready;
    logic  op = 1'b0;
    word_t a = '0;
    word_t b = '0;
    logic  out_valid;
    logic  out_ready = 1'b1;
    word_t result;
    logic  carry, overflow, zero, sign;

    int    tests = 0;
    int    fails = 0;
    int    out_count = 0;
    res_t  exp_q[$];
    logic  prev_stall = 1'b0;
    word_t prev_result;
    logic [3:0] prev_flags;

    pipe_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .carry    (carry),
        .overflow (overflow),
        .zero     (zero),
        .sign     (sign)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: exact signed arithmetic in a wider type, unsigned compare for borrow.
    function automatic res_t model(input logic o, input word_t x, input word_t y);
        res_t r;
        logic signed [WIDTH+1:0] sx, sy, exact;
        logic [WIDTH:0] usum;
        logic c, v, z, n;
        sx    = {{2{x[WIDTH-1]}}, x};
        sy    = {{2{y[WIDTH-1]}}, y};
        exact = o ? (sx - sy) : (sx + sy);
        usum  = {1'b0, x} + {1'b0, y};
        r.result = exact[WIDTH-1:0];
        c = o ? (x >= y) : usum[WIDTH];
        v = !((exact[WIDTH+1:WIDTH-1] == 3'b000) || (exact[WIDTH+1:WIDTH-1] == 3'b111));
        z = (r.result == '0);
        n = r.result[WIDTH-1];
        r.flags = CC_ON ? {c, v, z, n} : 4'b0000;
        return r;
    endfunction

    function automatic word_t pick_operand();
        case ($urandom_range(0, 7))
            0:       return '1;
            1:       return '0;
            2:       return {1'b1, {(WIDTH-1){1'b0}}};
            3:       return {1'b0, {(WIDTH-1){1'b1}}};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: sampled on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", WIDTH'(out_valid), WIDTH'(1));
                check("hold_result", result, prev_result);
                check("hold_flags", WIDTH'({carry, overflow, zero, sign}), WIDTH'(prev_flags));
            end
            check("ready_rule", WIDTH'(in_ready), WIDTH'(!(out_valid && !out_ready)));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out: got result 0x%0h, expected no output", result);
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    check("sb_result", result, e.result);
                    check("sb_flags", WIDTH'({carry, overflow, zero, sign}), WIDTH'(e.flags));
                    out_count++;
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(op, a, b));
            prev_stall  = out_valid && !out_ready;
            prev_result = result;
            prev_flags  = {carry, overflow, zero, sign};
        end
    end

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        bit seen;
        in_valid  = 1'b1;
        op        = v.op;
        a         = v.a;
        b         = v.b;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat <= 12) begin
            if (out_valid) seen = 1'b1;
            else begin
                tick();
                lat++;
            end
        end
        check($sformatf("vec%0d_latency", idx), WIDTH'(lat), WIDTH'(STAGES));
        check($sformatf("vec%0d_result", idx), result, v.exp_result);
        check($sformatf("vec%0d_flags", idx), WIDTH'({carry, overflow, zero, sign}),
              WIDTH'(CC_ON ? v.exp_flags : 4'b0000));
        tick();
    endtask

    task automatic drain(input string name);
        int budget;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        budget    = 0;
        while ((exp_q.size() != 0 || out_valid) && budget < 50) begin
            tick();
            budget++;
        end
        check(name, WIDTH'(exp_q.size()), WIDTH'(0));
    endtask

    task automatic stall_test();
        int issued;
        int base;
        issued = 0;
        base   = out_count;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            out_ready = !(cyc >= 5 && cyc <= 7);
            in_valid  = (issued < 6);
            op        = 1'($urandom_range(0, 1));
            a         = pick_operand();
            b         = pick_operand();
            #1;
            if (cyc >= 5 && cyc <= 7) check($sformatf("stall_in_ready_c%0d", cyc), WIDTH'(in_ready), WIDTH'(0));
            if (in_valid && in_ready) issued++;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stall_issued", WIDTH'(issued), WIDTH'(6));
        check("stall_delivered", WIDTH'(out_count - base), WIDTH'(6));
        check("stall_queue_empty", WIDTH'(exp_q.size()), WIDTH'(0));
    endtask

    task automatic reset_test();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            op       = 1'($urandom_range(0, 1));
            a        = pick_operand();
            b        = pick_operand();
            tick();
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        check("rst_out_valid", WIDTH'(out_valid), WIDTH'(0));
        check("rst_result", result, '0);
        check("rst_flags", WIDTH'({carry, overflow, zero, sign}), WIDTH'(0));
        rst = 1'b0;
        #1;
        check("rst_in_ready", WIDTH'(in_ready), WIDTH'(1));
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("no_stale_%0d", i), WIDTH'(out_valid), WIDTH'(0));
        end
    endtask

    task automatic random_test(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            op        = 1'($urandom_range(0, 1));
            a         = pick_operand();
            b         = pick_operand();
            tick();
        end
        drain("random_drained");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[8];
        vecs[0] = '{1'b0, 64'd5, 64'd7, 64'd12, 4'b0000};
        vecs[1] = '{1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 4'b0101};
        vecs[2] = '{1'b1, 64'd5, 64'd5, 64'd0, 4'b1010};
        vecs[3] = '{1'b0, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'h0000_0001_0000_0000, 4'b0000};
        vecs[4] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'b1010};
        vecs[5] = '{1'b1, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b1100};
        vecs[6] = '{1'b1, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0001};
        vecs[7] = '{1'b0, 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 64'h0001_0000_0001_0000, 4'b0000};

        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("reset_in_ready", WIDTH'(in_ready), WIDTH'(1));
        check("reset_out_valid", WIDTH'(out_valid), WIDTH'(0));
        check("reset_result", result, '0);
        check("reset_flags", WIDTH'({carry, overflow, zero, sign}), WIDTH'(0));

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);
        drain("vec_drained");

        stall_test();
        drain("stall_drained");

        reset_test();

        random_test(400);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pipe_addsub.md
PIPE_ADDSUB -- requirements
Module: pipe_addsub

Interface
REQ-001 Parameter WIDTH, default 64: operand and result width in bits; WIDTH SHALL be a multiple of STAGES.
REQ-002 Parameter STAGES, default 4: number of pipeline stages; each stage SHALL add one WIDTH/STAGES-bit slice.
REQ-003 Port clk, input, 1: single clock; all state SHALL update on the rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port in_valid, input, 1: an operation is offered this cycle.
REQ-006 Port in_ready, output, 1: the block accepts the offered operation this cycle.
REQ-007 Port op, input, 1: 0 = A+B, 1 = A-B.
REQ-008 Port a, input, WIDTH: signed operand A.
REQ-009 Port b, input, WIDTH: signed operand B.
REQ-010 Port out_valid, output, 1: result and flags are valid.
REQ-011 Port out_ready, input, 1: the consumer takes the result this cycle.
REQ-012 Port result, output, WIDTH: sum or difference, modulo 2^WIDTH.
REQ-013 Port carry, output, 1: carry out of the MSB; for subtraction 1 = no borrow.
REQ-014 Port overflow, output, 1: signed overflow.
REQ-015 Port zero, output, 1: result is all zeros.
REQ-016 Port sign, output, 1: result MSB.

Function
REQ-017 Subtraction SHALL be computed as A + ~B + 1; the op bit SHALL be the carry-in of slice 0 and SHALL select inversion of B.
REQ-018 Stage k SHALL add slice k using the carry registered from stage k-1; untouched slices of A and B and the finished low slices SHALL be carried forward in registers.
REQ-019 overflow SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-020 Latency SHALL be exactly STAGES cycles from acceptance (in_valid && in_ready) to out_valid when out_ready is held high.
REQ-021 Throughput SHALL be one operation per cycle when out_ready is held high.
REQ-022 The pipeline SHALL advance iff advance = !(out_valid && !out_ready); in_ready SHALL equal advance.
REQ-023 When advance = 0, every stage register and every output SHALL hold its value.
REQ-024 Bubbles (in_valid=0 on an accepted slot) SHALL propagate as invalid stages and SHALL never raise out_valid.
REQ-025 Results SHALL leave in acceptance order, with no loss or duplication under any out_ready pattern.
REQ-026 Simultaneous output drain and input acceptance in the same cycle SHALL be allowed and SHALL cause no stall.

Reset
REQ-027 While rst=1 at an edge, all stage valid bits, out_valid, result, carry, overflow, zero and sign SHALL become 0.
REQ-028 Reset mid-operation SHALL discard all in-flight operations; out_valid SHALL be 0 in the cycle after the reset edge.
REQ-029 in_ready SHALL be 1 in the first cycle after reset is deasserted.

Configuration
REQ-030 Macro PIPE_ADDSUB_CC_EN defined: carry, overflow, zero and sign SHALL be computed per REQ-013..REQ-016 and REQ-019.
REQ-031 Macro PIPE_ADDSUB_CC_EN undefined: carry, overflow, zero and sign SHALL be tied to 0, and their logic SHALL be absent; result and handshake behaviour SHALL be unchanged.

Verification (WIDTH=64, STAGES=4, PIPE_ADDSUB_CC_EN defined unless noted)
REQ-032 Add 5 + 7 with out_ready=1 -> result=12, zero=0, overflow=0, out_valid exactly 4 cycles after acceptance.
REQ-033 Sub 0x7FFFFFFFFFFFFFFF - 0xFFFFFFFFFFFFFFFF -> result=0x8000000000000000, overflow=1, sign=1.
REQ-034 Sub 5 - 5 -> result=0, zero=1, carry=1; add 0x00000000FFFFFFFF + 1 -> result=0x0000000100000000, with the carry crossing a slice boundary.
REQ-035 Issue 6 back-to-back ops with out_ready=0 for cycles 5..7 -> in_ready=0 during the stall, all 6 results appear in order, and none are lost.
REQ-036 Assert rst with 3 ops in flight -> out_valid=0 the next cycle and no stale result afterwards; with PIPE_ADDSUB_CC_EN undefined, repeat REQ-033 -> flags=0 and result unchanged.
